// File: rtl/pipe_ctrl_n_if.sv
// rtl/pipe_ctrl_n_if.sv - stall/flush controller pipeline-side signal bundle
`timescale 1ns/1ps

interface pipe_ctrl_n_if #(
    parameter int STAGES = 6,
    parameter int ADDR_W = 32,
    parameter int VOFF_W = 12,
    parameter int CNT_W  = 32
);
    logic [STAGES-1:0] stallreq;
    logic              exc_valid;
    logic              exc_eret;
    logic [VOFF_W-1:0] exc_voff;
    logic [ADDR_W-1:0] cp0_epc;
    logic [ADDR_W-1:0] cp0_ebase;
    logic [STAGES-1:0] stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              stall_timeout;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output stallreq, exc_valid, exc_eret, exc_voff, cp0_epc, cp0_ebase,
        input  stall, flush, new_pc, stall_timeout, stall_cnt
    );

    modport slave (
        input  stallreq, exc_valid, exc_eret, exc_voff, cp0_epc, cp0_ebase,
        output stall, flush, new_pc, stall_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_n.sv
// rtl/pipe_ctrl_n.sv - parametrised pipeline stall/flush controller
`timescale 1ns/1ps

module pipe_ctrl_n #(
    parameter int STAGES       = 6,
    parameter int ADDR_W       = 32,
    parameter int VOFF_W       = 12,
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_W        = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_n_if.slave bus
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] hold_q, hold_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [STAGES-1:0] req_mask;
    logic              upper_any;
    logic [ADDR_W-1:0] exc_pc;
    logic              accept;
    logic              flush_c;
    logic [STAGES-1:0] stall_c;

    // A request at stage k holds k and everything upstream; a lone fetch
    // wait (bit 0) freezes the whole pipeline.
    always_comb begin
        upper_any = 1'b0;
        req_mask  = '0;
        for (int i = STAGES - 1; i >= 1; i--) begin
            upper_any   = upper_any | bus.stallreq[i];
            req_mask[i] = upper_any;
        end
        req_mask[0] = upper_any | bus.stallreq[0];
        if (!upper_any && bus.stallreq[0]) begin
            req_mask = '1;
        end
    end

    always_comb begin
        exc_pc = bus.exc_eret ? bus.cp0_epc : (bus.cp0_ebase + ADDR_W'(bus.exc_voff));
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        hold_d  = hold_q;
        accept  = 1'b0;
        flush_c = 1'b0;
        stall_c = '0;
        case (state_q)
            RUN: begin
                if (bus.exc_valid) begin
                    accept  = 1'b1;
                    flush_c = 1'b1;
                    hold_d  = exc_pc;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                    end
                end else begin
                    stall_c = req_mask;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                fcnt_d  = fcnt_q - FC_W'(1);
                if (fcnt_q == FC_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Watchdog and perf counter both saturate; a flush cycle clears the sticky flag.
    always_comb begin
        wd_d  = wd_q;
        tmo_d = tmo_q;
        cnt_d = cnt_q;
        if (stall_c != '0) begin
            if (wd_q == WD_MAX) begin
                tmo_d = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            wd_d = '0;
        end
        if (flush_c) begin
            tmo_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            hold_q  <= '0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            hold_q  <= hold_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.stall         = rst ? '0 : stall_c;
        bus.flush         = !rst && flush_c;
        bus.new_pc        = rst ? '0 : (accept ? exc_pc : hold_q);
        bus.stall_timeout = !rst && tmo_q;
        bus.stall_cnt     = rst ? '0 : cnt_q;
    end
endmodule

// File: tb/tb_pipe_ctrl_n.sv
// tb/tb_pipe_ctrl_n.sv - scoreboard bench for pipe_ctrl_n
`timescale 1ns/1ps

module tb_pipe_ctrl_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_n_if #(.STAGES(6), .ADDR_W(32), .VOFF_W(12), .CNT_W(32)) ifa();
    pipe_ctrl_n_if #(.STAGES(6), .ADDR_W(32), .VOFF_W(12), .CNT_W(4))  ifb();

    pipe_ctrl_n #(.STAGES(6), .ADDR_W(32), .VOFF_W(12), .FLUSH_CYCLES(3),
                  .TIMEOUT(8), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pipe_ctrl_n #(.STAGES(6), .ADDR_W(32), .VOFF_W(12), .FLUSH_CYCLES(1),
                  .TIMEOUT(1024), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct {
        logic        r;
        logic [5:0]  req;
        logic        ev;
        logic        er;
        logic [11:0] voff;
        logic [31:0] epc;
        logic [31:0] ebase;
    } stim_t;

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        chk_pc;
        logic        tmo;
        logic [31:0] cnt;
        logic        chk_wd;
    } exp_t;

    exp_t  sb[$];
    stim_t st[$];

    function automatic stim_t mk(logic r, logic [5:0] req, logic ev, logic er,
                                 logic [11:0] voff, logic [31:0] epc, logic [31:0] ebase);
        stim_t s;
        s.r = r; s.req = req; s.ev = ev; s.er = er; s.voff = voff; s.epc = epc; s.ebase = ebase;
        return s;
    endfunction

    function automatic exp_t ex(string name, logic [5:0] stall, logic flush, logic [31:0] pc,
                                logic chk_pc, logic tmo, logic [31:0] cnt, logic chk_wd);
        exp_t e;
        e.name = name; e.stall = stall; e.flush = flush; e.pc = pc; e.chk_pc = chk_pc;
        e.tmo = tmo; e.cnt = cnt; e.chk_wd = chk_wd;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input stim_t s);
        rst           = s.r;
        ifa.stallreq  = s.req;
        ifa.exc_valid = s.ev;
        ifa.exc_eret  = s.er;
        ifa.exc_voff  = s.voff;
        ifa.cp0_epc   = s.epc;
        ifa.cp0_ebase = s.ebase;
    endtask

    task automatic do_reset();
        tick();
        apply(mk(1'b1, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
        tick();
        apply(mk(1'b0, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
    endtask

    task automatic test_reset();
        st.push_back(mk(1'b1, 6'b000100, 1'b1, 1'b0, 12'h180, 32'h1111_0000, 32'h8000_0000));
        sb.push_back(ex("rst_forced", 6'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 1'b1));
        st.push_back(mk(1'b1, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
        sb.push_back(ex("rst_hold", 6'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 1'b1));
        st.push_back(mk(1'b0, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
        sb.push_back(ex("rst_state", 6'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 1'b1));
        while (st.size() > 0) begin
            exp_t e;
            tick();
            apply(st.pop_front());
            #3;
            e = sb.pop_front();
            checks++;
            if (ifa.stall !== e.stall) begin errors++; $display("FAIL %s stall got %b exp %b", e.name, ifa.stall, e.stall); end
            checks++;
            if (ifa.flush !== e.flush) begin errors++; $display("FAIL %s flush got %b exp %b", e.name, ifa.flush, e.flush); end
            checks++;
            if (ifa.new_pc !== e.pc) begin errors++; $display("FAIL %s new_pc got %h exp %h", e.name, ifa.new_pc, e.pc); end
            checks++;
            if (ifa.stall_timeout !== e.tmo) begin errors++; $display("FAIL %s timeout got %b exp %b", e.name, ifa.stall_timeout, e.tmo); end
            checks++;
            if (ifa.stall_cnt !== e.cnt) begin errors++; $display("FAIL %s stall_cnt got %0d exp %0d", e.name, ifa.stall_cnt, e.cnt); end
        end
    endtask

    task automatic test_stall_mask();
        logic [5:0] reqs [5]  = '{6'b000100, 6'b010110, 6'b000001, 6'b100000, 6'b000000};
        logic [5:0] masks [5] = '{6'b000111, 6'b011111, 6'b111111, 6'b111111, 6'b000000};
        for (int i = 0; i < 5; i++) begin
            st.push_back(mk(1'b0, reqs[i], 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
            sb.push_back(ex($sformatf("mask_%0d", i), masks[i], 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0));
        end
        while (st.size() > 0) begin
            exp_t e;
            tick();
            apply(st.pop_front());
            #3;
            e = sb.pop_front();
            checks++;
            if (ifa.stall !== e.stall) begin errors++; $display("FAIL %s stall got %b exp %b", e.name, ifa.stall, e.stall); end
            checks++;
            if (ifa.flush !== e.flush) begin errors++; $display("FAIL %s flush got %b exp %b", e.name, ifa.flush, e.flush); end
        end
    endtask

    task automatic test_flush_seq();
        st.push_back(mk(1'b0, 6'b000010, 1'b1, 1'b0, 12'h180, 32'h0, 32'h8000_0000));
        sb.push_back(ex("flush_c1", 6'b0, 1'b1, 32'h8000_0180, 1'b1, 1'b0, 32'd0, 1'b0));
        st.push_back(mk(1'b0, 6'b111111, 1'b1, 1'b0, 12'h000, 32'h0, 32'h1234_0000));
        sb.push_back(ex("flush_c2", 6'b0, 1'b1, 32'h8000_0180, 1'b1, 1'b0, 32'd0, 1'b0));
        st.push_back(mk(1'b0, 6'b000000, 1'b1, 1'b0, 12'h000, 32'h0, 32'h1234_0000));
        sb.push_back(ex("flush_c3", 6'b0, 1'b1, 32'h8000_0180, 1'b1, 1'b0, 32'd0, 1'b0));
        st.push_back(mk(1'b0, 6'b000000, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0));
        sb.push_back(ex("flush_end", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0));
        st.push_back(mk(1'b0, 6'b000100, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0));
        sb.push_back(ex("flush_resume", 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0));
        while (st.size() > 0) begin
            exp_t e;
            tick();
            apply(st.pop_front());
            #3;
            e = sb.pop_front();
            checks++;
            if (ifa.stall !== e.stall) begin errors++; $display("FAIL %s stall got %b exp %b", e.name, ifa.stall, e.stall); end
            checks++;
            if (ifa.flush !== e.flush) begin errors++; $display("FAIL %s flush got %b exp %b", e.name, ifa.flush, e.flush); end
            if (e.chk_pc) begin
                checks++;
                if (ifa.new_pc !== e.pc) begin errors++; $display("FAIL %s new_pc got %h exp %h", e.name, ifa.new_pc, e.pc); end
            end
        end
    endtask

    task automatic test_eret_wrap_back_to_back();
        st.push_back(mk(1'b0, 6'b001000, 1'b1, 1'b1, 12'h180, 32'hBFC0_0010, 32'h8000_0000));
        sb.push_back(ex("eret_c1", 6'b0, 1'b1, 32'hBFC0_0010, 1'b1, 1'b0, 32'd0, 1'b0));
        for (int i = 2; i <= 3; i++) begin
            st.push_back(mk(1'b0, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
            sb.push_back(ex($sformatf("eret_c%0d", i), 6'b0, 1'b1, 32'hBFC0_0010, 1'b1, 1'b0, 32'd0, 1'b0));
        end
        st.push_back(mk(1'b0, 6'b000001, 1'b1, 1'b0, 12'h200, 32'hBFC0_0010, 32'hFFFF_FF00));
        sb.push_back(ex("wrap_c1", 6'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'd0, 1'b0));
        for (int i = 2; i <= 3; i++) begin
            st.push_back(mk(1'b0, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
            sb.push_back(ex($sformatf("wrap_c%0d", i), 6'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'd0, 1'b0));
        end
        st.push_back(mk(1'b0, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
        sb.push_back(ex("wrap_end", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0));
        while (st.size() > 0) begin
            exp_t e;
            tick();
            apply(st.pop_front());
            #3;
            e = sb.pop_front();
            checks++;
            if (ifa.stall !== e.stall) begin errors++; $display("FAIL %s stall got %b exp %b", e.name, ifa.stall, e.stall); end
            checks++;
            if (ifa.flush !== e.flush) begin errors++; $display("FAIL %s flush got %b exp %b", e.name, ifa.flush, e.flush); end
            if (e.chk_pc) begin
                checks++;
                if (ifa.new_pc !== e.pc) begin errors++; $display("FAIL %s new_pc got %h exp %h", e.name, ifa.new_pc, e.pc); end
            end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            st.push_back(mk(1'b0, 6'b000100, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
            sb.push_back(ex($sformatf("wd_stall%0d", i), 6'b000111, 1'b0, 32'h0, 1'b0,
                            (i >= 9), 32'(i - 1), 1'b1));
        end
        for (int i = 11; i <= 12; i++) begin
            st.push_back(mk(1'b0, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
            sb.push_back(ex($sformatf("wd_idle%0d", i), 6'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'd10, 1'b1));
        end
        st.push_back(mk(1'b0, 6'b000100, 1'b1, 1'b0, 12'h004, 32'h0, 32'h0000_1000));
        sb.push_back(ex("wd_exc", 6'b0, 1'b1, 32'h0000_1004, 1'b1, 1'b1, 32'd10, 1'b1));
        for (int i = 2; i <= 3; i++) begin
            st.push_back(mk(1'b0, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
            sb.push_back(ex($sformatf("wd_flush%0d", i), 6'b0, 1'b1, 32'h0000_1004, 1'b1, 1'b0, 32'd10, 1'b1));
        end
        st.push_back(mk(1'b0, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
        sb.push_back(ex("wd_after", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd10, 1'b1));
        while (st.size() > 0) begin
            exp_t e;
            tick();
            apply(st.pop_front());
            #3;
            e = sb.pop_front();
            checks++;
            if (ifa.stall !== e.stall) begin errors++; $display("FAIL %s stall got %b exp %b", e.name, ifa.stall, e.stall); end
            checks++;
            if (ifa.flush !== e.flush) begin errors++; $display("FAIL %s flush got %b exp %b", e.name, ifa.flush, e.flush); end
            if (e.chk_pc) begin
                checks++;
                if (ifa.new_pc !== e.pc) begin errors++; $display("FAIL %s new_pc got %h exp %h", e.name, ifa.new_pc, e.pc); end
            end
            checks++;
            if (ifa.stall_timeout !== e.tmo) begin errors++; $display("FAIL %s timeout got %b exp %b", e.name, ifa.stall_timeout, e.tmo); end
            checks++;
            if (ifa.stall_cnt !== e.cnt) begin errors++; $display("FAIL %s stall_cnt got %0d exp %0d", e.name, ifa.stall_cnt, e.cnt); end
        end
    endtask

    task automatic test_cnt_saturate();
        for (int i = 0; i < 22; i++) begin
            sb.push_back(ex($sformatf("sat_%0d", i), (i < 20) ? 6'b111111 : 6'b000000, 1'b0, 32'h0,
                            1'b0, 1'b0, 32'((i > 15) ? 15 : i), 1'b1));
        end
        for (int i = 0; i < 22; i++) begin
            exp_t e;
            tick();
            ifb.stallreq = (i < 20) ? 6'b000001 : 6'b000000;
            #3;
            e = sb.pop_front();
            checks++;
            if (ifb.stall !== e.stall) begin errors++; $display("FAIL %s stall got %b exp %b", e.name, ifb.stall, e.stall); end
            checks++;
            if (32'(ifb.stall_cnt) !== e.cnt) begin errors++; $display("FAIL %s stall_cnt got %0d exp %0d", e.name, ifb.stall_cnt, e.cnt); end
        end
    endtask

    task automatic test_rst_mid_flush();
        st.push_back(mk(1'b0, 6'b0, 1'b1, 1'b0, 12'h678, 32'h0, 32'h1234_5000));
        sb.push_back(ex("rmf_exc", 6'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'd10, 1'b1));
        st.push_back(mk(1'b1, 6'b000100, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
        sb.push_back(ex("rmf_rst", 6'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 1'b1));
        st.push_back(mk(1'b0, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
        sb.push_back(ex("rmf_after", 6'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 1'b1));
        st.push_back(mk(1'b0, 6'b000100, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
        sb.push_back(ex("rmf_run", 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b1));
        while (st.size() > 0) begin
            exp_t e;
            tick();
            apply(st.pop_front());
            #3;
            e = sb.pop_front();
            checks++;
            if (ifa.stall !== e.stall) begin errors++; $display("FAIL %s stall got %b exp %b", e.name, ifa.stall, e.stall); end
            checks++;
            if (ifa.flush !== e.flush) begin errors++; $display("FAIL %s flush got %b exp %b", e.name, ifa.flush, e.flush); end
            if (e.chk_pc) begin
                checks++;
                if (ifa.new_pc !== e.pc) begin errors++; $display("FAIL %s new_pc got %h exp %h", e.name, ifa.new_pc, e.pc); end
            end
            checks++;
            if (ifa.stall_timeout !== e.tmo) begin errors++; $display("FAIL %s timeout got %b exp %b", e.name, ifa.stall_timeout, e.tmo); end
            checks++;
            if (ifa.stall_cnt !== e.cnt) begin errors++; $display("FAIL %s stall_cnt got %0d exp %0d", e.name, ifa.stall_cnt, e.cnt); end
        end
    endtask

    initial begin
        apply(mk(1'b1, 6'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0));
        ifb.stallreq  = '0;
        ifb.exc_valid = 1'b0;
        ifb.exc_eret  = 1'b0;
        ifb.exc_voff  = '0;
        ifb.cp0_epc   = '0;
        ifb.cp0_ebase = '0;
        test_reset();
        test_stall_mask();
        test_flush_seq();
        test_eret_wrap_back_to_back();
        test_watchdog();
        test_cnt_saturate();
        test_rst_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_n.md
# pipe_ctrl_n

Parametrised pipeline stall/flush controller for the CPU, successor to the fixed six-stage controller. It resolves per-stage stall requests into a stall mask over `STAGES` stages and sequences exception flushes over a configurable number of cycles. It computes the exception redirect PC: EPC for ERET, otherwise EBASE plus a vector offset. It also keeps a stall watchdog and a saturating stall-cycle performance counter. It sits beside the pipeline registers and drives their stall/flush inputs and the PC module's redirect.

## Interface
- `STAGES`, 6, number of pipeline stages; index 0 = PC, index STAGES-1 = WB; min 2.
- `ADDR_W`, 32, PC/EPC/EBASE width.
- `VOFF_W`, 12, exception vector offset width.
- `FLUSH_CYCLES`, 1, cycles flush is held per exception; min 1.
- `TIMEOUT`, 1024, consecutive stalled cycles that trip the watchdog; min 2.
- `CNT_W`, 32, performance counter width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stallreq`  in  STAGES  per-stage stall request; bit 0 = PC/fetch bus wait.
- `exc_valid`  in  1  final exception present this cycle.
- `exc_eret`  in  1  exception is ERET; qualified by exc_valid.
- `exc_voff`  in  VOFF_W  vector offset added to EBASE.
- `cp0_epc`  in  ADDR_W  current EPC.
- `cp0_ebase`  in  ADDR_W  current EBASE.
- `stall`  out  STAGES  stall mask; bit k = stage k holds.
- `flush`  out  1  flush all pipeline registers.
- `new_pc`  out  ADDR_W  redirect PC; valid while flush=1.
- `stall_timeout`  out  1  sticky watchdog flag.
- `stall_cnt`  out  CNT_W  total stalled cycles, saturating.

## Operation
- States: RUN, FLUSH.
- Stall mask (RUN, exc_valid=0):
  - Let k be the highest set index of stallreq with k≥1. Then stall = bits k..0 set, all higher bits clear.
  - If only stallreq[0] is set, stall = all ones. This is a fetch bus wait and freezes the whole pipeline.
  - If no request is set, stall = 0.
- Exception:
  - exc_valid=1 in RUN has absolute priority over all stall requests.
  - Outputs that cycle: flush=1, stall=0.
  - new_pc = exc_eret ? cp0_epc : cp0_ebase + zero-extended exc_voff, truncated to ADDR_W (wrap-around).
  - new_pc is captured into a hold register.
  - If FLUSH_CYCLES>1, the FSM goes to FLUSH with remaining-count FLUSH_CYCLES-1.
- FLUSH state:
  - Outputs: flush=1, stall=0, new_pc = held value.
  - exc_valid and stallreq are ignored.
  - The count decrements each cycle; the FSM returns to RUN on the cycle the count reaches 0.
- new_pc outside flush equals the hold register. Its value is don't-care to consumers.
- Watchdog:
  - Counter increments each cycle stall≠0 and resets to 0 on any cycle stall=0.
  - When it reaches TIMEOUT-1 while stall≠0, stall_timeout is set on the next edge.
  - The counter saturates at TIMEOUT-1.
  - stall_timeout clears only on rst or on any cycle flush=1.
- stall_cnt increments on each cycle stall≠0 and saturates at all ones.

## Timing
- Stall mask, flush, and new_pc in the first exception cycle are combinational from inputs: zero-cycle latency, same as the previous controller.
- Flush lasts exactly FLUSH_CYCLES consecutive cycles per accepted exception.
- An exception arriving on the cycle FLUSH returns to RUN is ignored, because the FSM is still in FLUSH.
- An exception on the first RUN cycle after FLUSH is accepted.
- Reset values: state RUN, flush count 0, hold PC 0, stall 0, flush 0, new_pc 0, stall_timeout 0, stall_cnt 0, watchdog 0.
- While rst=1 all outputs are forced to their reset values, independent of inputs.
- rst asserted mid-FLUSH aborts the flush; flush=0 on the cycle after rst is sampled.
- Simultaneous exc_valid with stall requests: flush wins, stall=0, and the watchdog resets.

## Test plan
- STAGES=6: stallreq=6'b000100 → stall=000111. stallreq=6'b010110 → stall=011111. stallreq=6'b000001 → stall=111111. stallreq=0 → stall=0.
- FLUSH_CYCLES=3, exc_valid pulse with exc_eret=0, ebase=0x8000_0000, voff=0x180 → flush high exactly 3 cycles, new_pc=0x8000_0180 throughout. A second exc_valid during cycle 2 is ignored.
- ERET with epc=0xBFC0_0010 while stallreq=6'b001000 → flush=1, stall=0, new_pc=0xBFC0_0010.
- Wrap: ebase=0xFFFF_FF00, voff=0x200 → new_pc=0x0000_0100.
- TIMEOUT=8, stallreq[2] held 10 cycles:
  - stall_timeout rises after the 8th stalled cycle and stays high after the request drops.
  - An exception clears it.
  - stall_cnt=10.
- CNT_W=4, 20 stalled cycles → stall_cnt=15.
- rst asserted during flush cycle 1 of 3 → next cycle all outputs at reset values.
